ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_pkg.sv | 51 +++++
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_port_arbiter_rr_lock_arb.sv | 102 ++++++++++
 rtl/ram_port_arbiter.sv | 113 +++++++++++
 tb/tb_ram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
//   Shared types and helpers for the staging-RAM port arbiter.
//   - MAX_CLIENTS : upper bound on requesters; sizes the round-robin helper.
//   - PTR_W       : width of a client index / priority pointer.
//   - arb_state_e : per-arbiter FSM state (idle round-robin vs. locked burst).
//   - rr_pick     : one-hot round-robin pick starting at a priority pointer.
//   - rr_next     : index + 1 with wrap at numClients - 1.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int PTR_W       = $clog2(MAX_CLIENTS);

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Scans clients ptr, ptr+1, ... (mod numClients) and returns the first
  // requester as a one-hot vector; all zeros when nobody requests.
  function automatic logic [MAX_CLIENTS-1:0] rr_pick(
    input logic [MAX_CLIENTS-1:0] req,
    input logic [PTR_W-1:0]       ptr,
    input int                     numClients
  );
    logic [MAX_CLIENTS-1:0] grant;
    logic                   found;
    int                     idx;
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < MAX_CLIENTS; off++) begin
      // ptr < numClients and off < numClients, so one subtraction wraps.
      idx = int'(ptr) + off;
      if (idx >= numClients) idx -= numClients;
      if (off < numClients && !found && req[PTR_W'(idx)]) begin
        grant[PTR_W'(idx)] = 1'b1;
        found              = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [PTR_W-1:0] rr_next(
    input logic [PTR_W-1:0] idx,
    input int               numClients
  );
    return (int'(idx) == numClients - 1) ? '0 : idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//   Client-side bundle between the DMA requesters and ram_port_arbiter.
//   Write request : wr_req_valid/last/addr/data in, wr_req_ready out (one-hot)
//   Read request  : rd_req_valid/last/addr in, rd_req_ready out (one-hot)
//   Read response : rd_rsp_valid (one-hot, one cycle after grant), rd_rsp_data
//   Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128
);

  logic [NUM_CLIENTS-1:0]        wr_req_valid;
  logic [NUM_CLIENTS-1:0]        wr_req_last;
  logic [NUM_CLIENTS*ADDR_W-1:0] wr_req_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] wr_req_data;
  logic [NUM_CLIENTS-1:0]        wr_req_ready;

  logic [NUM_CLIENTS-1:0]        rd_req_valid;
  logic [NUM_CLIENTS-1:0]        rd_req_last;
  logic [NUM_CLIENTS*ADDR_W-1:0] rd_req_addr;
  logic [NUM_CLIENTS-1:0]        rd_req_ready;

  logic [NUM_CLIENTS-1:0]        rd_rsp_valid;
  logic [DATA_W-1:0]             rd_rsp_data;

  modport master (
    output wr_req_valid, wr_req_last, wr_req_addr, wr_req_data,
    output rd_req_valid, rd_req_last, rd_req_addr,
    input  wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_req_valid, wr_req_last, wr_req_addr, wr_req_data,
    input  rd_req_valid, rd_req_last, rd_req_addr,
    output wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
  );

endinterface

// File: rtl/ram_port_arbiter_rr_lock_arb.sv
// ---------------------------------------------------------------------------
// rr_lock_arb
//   Round-robin arbiter with burst locking for one RAM port.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     reqValid  : per-client request
//     reqLast   : per-client final-beat flag
//     grant     : one-hot grant, combinational; never set without reqValid
//   In IDLE the pick starts at ptr. A granted beat without last locks the
//   port to that client until its last beat; ptr then moves past the owner.
// ---------------------------------------------------------------------------
module rr_lock_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] reqValid,
  input  logic [NUM_CLIENTS-1:0] reqLast,
  output logic [NUM_CLIENTS-1:0] grant
);

  arb_state_e             state, stateNext;
  logic [PTR_W-1:0]       ptr, ptrNext;
  logic [PTR_W-1:0]       owner, ownerNext;
  logic [NUM_CLIENTS-1:0] idleGrant;
  logic [PTR_W-1:0]       pickIdx;
  logic                   pickLast;
  logic                   ownerValid;
  logic                   ownerLast;

  assign idleGrant = NUM_CLIENTS'(rr_pick(MAX_CLIENTS'(reqValid), ptr, NUM_CLIENTS));

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    ownerNext  = owner;
    grant      = '0;
    pickIdx    = '0;
    pickLast   = 1'b0;
    ownerValid = 1'b0;
    ownerLast  = 1'b0;

    case (state)
      ARB_IDLE: begin
        grant = idleGrant;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (idleGrant[i]) begin
            pickIdx  = PTR_W'(i);
            pickLast = reqLast[i];
          end
        end
        if (|idleGrant) begin
          if (pickLast) begin
            ptrNext = rr_next(pickIdx, NUM_CLIENTS);
          end else begin
            stateNext = ARB_LOCKED;
            ownerNext = pickIdx;
          end
        end
      end

      ARB_LOCKED: begin
        // Only the owner can be granted; its idle cycles hold the lock.
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (PTR_W'(i) == owner) begin
            grant[i]   = reqValid[i];
            ownerValid = reqValid[i];
            ownerLast  = reqLast[i];
          end
        end
        if (ownerValid && ownerLast) begin
          stateNext = ARB_IDLE;
          ptrNext   = rr_next(owner, NUM_CLIENTS);
        end
      end

      default: stateNext = ARB_IDLE;
    endcase

    // Grants (and hence RAM enables) are held off for the whole reset cycle.
    if (rst) grant = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      owner <= ownerNext;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares a single-write/single-read staging RAM between NUM_CLIENTS DMA
//   requesters using two independent round-robin, burst-locking arbiters.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     bus (slave)   : client write/read requests and read responses
//     ram_wr_en/addr/data : RAM write pins
//     ram_rd_en/addr      : RAM read pins
//     ram_rd_data         : RAM read data, registered, 1-cycle latency
//   Optional build macro RAM_ARB_WR_FWD_EN: a read issued in the same cycle
//   as a write to the same address returns the new write data instead of the
//   old RAM contents.
//   NUM_CLIENTS must be in 2..8.
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  logic [NUM_CLIENTS-1:0] wrGrant, rdGrant;
  logic [NUM_CLIENTS-1:0] wrFire, rdFire;
  logic [NUM_CLIENTS-1:0] rspValid;

  rr_lock_arb #(.NUM_CLIENTS(NUM_CLIENTS)) u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .reqValid (bus.wr_req_valid),
    .reqLast  (bus.wr_req_last),
    .grant    (wrGrant)
  );

  rr_lock_arb #(.NUM_CLIENTS(NUM_CLIENTS)) u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .reqValid (bus.rd_req_valid),
    .reqLast  (bus.rd_req_last),
    .grant    (rdGrant)
  );

  assign bus.wr_req_ready = wrGrant;
  assign bus.rd_req_ready = rdGrant;
  assign wrFire           = bus.wr_req_valid & wrGrant;
  assign rdFire           = bus.rd_req_valid & rdGrant;
  assign ram_wr_en        = |wrFire;
  assign ram_rd_en        = |rdFire;

  // Fire vectors are one-hot or zero, so an OR-reduction mux is exact and
  // yields zero address/data when nobody is granted.
  always_comb begin
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (wrFire[i]) begin
        ram_wr_addr |= bus.wr_req_addr[i*ADDR_W +: ADDR_W];
        ram_wr_data |= bus.wr_req_data[i*DATA_W +: DATA_W];
      end
      if (rdFire[i]) begin
        ram_rd_addr |= bus.rd_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Issuing-client tag travels alongside the RAM's one-cycle read latency.
  // NOTE: only control state is reset; the forwarded data register below is
  // qualified by the reset hit flag and needs no reset of its own.
  always_ff @(posedge clk) begin
    if (rst) rspValid <= '0;
    else     rspValid <= rdFire;
  end

  assign bus.rd_rsp_valid = rspValid;

`ifdef RAM_ARB_WR_FWD_EN
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;

  always_ff @(posedge clk) begin
    if (rst) fwdHit <= 1'b0;
    else     fwdHit <= ram_wr_en && ram_rd_en && (ram_wr_addr == ram_rd_addr);
  end

  always_ff @(posedge clk) begin
    fwdData <= ram_wr_data;
  end

  always_comb begin
    bus.rd_rsp_data = '0;
    if (|rspValid) bus.rd_rsp_data = fwdHit ? fwdData : ram_rd_data;
  end
`else
  // Same-cycle write/read to one address returns the RAM's old contents.
  always_comb begin
    bus.rd_rsp_data = '0;
    if (|rspValid) bus.rd_rsp_data = ram_rd_data;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter (NUM_CLIENTS = 2) with a
//   behavioural 256-word RAM model (registered read, read-before-write).
//   Write-side arbitration is table driven; read latency, collisions and
//   reset mid-burst are hand-written sequences. Read responses are checked
//   by a scoreboard queue keyed on the cycle the response is due.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  ram_port_arbiter_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [DW-1:0] mem [256];
  initial ram_rd_data = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr[7:0]] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[7:0]];
  end

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  bit monOn   = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected read responses
  typedef struct {
    int            due;
    logic [NC-1:0] vec;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sbQ[$];

  task automatic expect_rsp(input logic [NC-1:0] vec, input logic [DW-1:0] data);
    rsp_t e;
    e.due  = cycle + 1;
    e.vec  = vec;
    e.data = data;
    sbQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (sbQ.size() > 0 && sbQ[0].due == cycle) begin
        rsp_t e;
        e = sbQ.pop_front();
        check("rsp_valid", 128'(bus.rd_rsp_valid), 128'(e.vec));
        check("rsp_data", bus.rd_rsp_data, e.data);
      end else begin
        check("rsp_idle", 128'(bus.rd_rsp_valid), 128'(0));
      end
    end
  end

  // Write-side vector table
  typedef struct {
    string         name;
    logic          rst;
    logic [NC-1:0] wv;
    logic [NC-1:0] wl;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [NC-1:0] expReady;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [DW-1:0] data_of(input int client, input logic [AW-1:0] addr);
    return (client == 0) ? {4{addr}} : ~{4{addr}};
  endfunction

  task automatic add_row(input string name, input logic r, input logic [NC-1:0] wv,
                         input logic [NC-1:0] wl, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [NC-1:0] expReady);
    vec_t v;
    v.name = name; v.rst = r; v.wv = wv; v.wl = wl;
    v.a0 = a0; v.a1 = a1; v.expReady = expReady;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_req_valid = '0;
    bus.wr_req_last  = '0;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
    bus.rd_req_valid = '0;
    bus.rd_req_last  = '0;
    bus.rd_req_addr  = '0;
  endtask

  task automatic drive_wr(input logic [NC-1:0] v, input logic [NC-1:0] l,
                          input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.wr_req_valid = v;
    bus.wr_req_last  = l;
    bus.wr_req_addr  = {a1, a0};
    bus.wr_req_data  = {d1, d0};
  endtask

  task automatic drive_rd(input logic [NC-1:0] v, input logic [NC-1:0] l,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_req_valid = v;
    bus.rd_req_last  = l;
    bus.rd_req_addr  = {a1, a0};
  endtask

  logic [DW-1:0] collExp;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;

  initial begin
`ifdef RAM_ARB_WR_FWD_EN
    collExp = 128'h1;
`else
    collExp = 128'h9;
`endif
    // Table: write-side round robin, burst lock, locked gap, reset mid-burst
    add_row("rst_hold",        1'b1, 2'b11, 2'b11, 32'h100, 32'h200, 2'b00);
    add_row("rr_0",            1'b0, 2'b11, 2'b11, 32'h100, 32'h200, 2'b01);
    add_row("rr_1",            1'b0, 2'b11, 2'b11, 32'h101, 32'h201, 2'b10);
    add_row("rr_2",            1'b0, 2'b11, 2'b11, 32'h102, 32'h202, 2'b01);
    add_row("rr_3",            1'b0, 2'b11, 2'b11, 32'h103, 32'h203, 2'b10);
    add_row("burst_b1",        1'b0, 2'b01, 2'b00, 32'h010, 32'h000, 2'b01);
    add_row("burst_b2",        1'b0, 2'b11, 2'b00, 32'h011, 32'h300, 2'b01);
    add_row("burst_b3_last",   1'b0, 2'b11, 2'b01, 32'h012, 32'h300, 2'b01);
    add_row("ptr_after_burst", 1'b0, 2'b11, 2'b11, 32'h013, 32'h301, 2'b10);
    add_row("rr_back",         1'b0, 2'b11, 2'b11, 32'h014, 32'h302, 2'b01);
    add_row("gap_b1",          1'b0, 2'b01, 2'b00, 32'h020, 32'h000, 2'b01);
    add_row("gap_hold1",       1'b0, 2'b10, 2'b10, 32'h000, 32'h303, 2'b00);
    add_row("gap_hold2",       1'b0, 2'b10, 2'b10, 32'h000, 32'h303, 2'b00);
    add_row("gap_last",        1'b0, 2'b11, 2'b01, 32'h021, 32'h303, 2'b01);
    add_row("gap_release",     1'b0, 2'b10, 2'b10, 32'h000, 32'h303, 2'b10);
    add_row("wr_rst_b1",       1'b0, 2'b01, 2'b00, 32'h022, 32'h000, 2'b01);
    add_row("wr_rst_apply",    1'b1, 2'b11, 2'b00, 32'h023, 32'h304, 2'b00);
    add_row("wr_rst_release",  1'b0, 2'b11, 2'b11, 32'h024, 32'h305, 2'b01);

    rst = 1'b1;
    idle_inputs();

    // Reset state
    step();
    @(negedge clk);
    check("rst_wr_ready", 128'(bus.wr_req_ready), 128'(0));
    check("rst_rd_ready", 128'(bus.rd_req_ready), 128'(0));
    check("rst_rsp_valid", 128'(bus.rd_rsp_valid), 128'(0));
    check("rst_rsp_data", bus.rd_rsp_data, 128'(0));
    check("rst_ram_en", 128'({ram_wr_en, ram_rd_en}), 128'(0));
    check("rst_ram_addr", 128'({ram_wr_addr, ram_rd_addr}), 128'(0));
    check("rst_ram_wdata", ram_wr_data, 128'(0));
    monOn = 1'b1;

    foreach (vecs[k]) begin
      step();
      rst = vecs[k].rst;
      drive_wr(vecs[k].wv, vecs[k].wl, vecs[k].a0, data_of(0, vecs[k].a0),
               vecs[k].a1, data_of(1, vecs[k].a1));
      expAddr = (vecs[k].expReady == 2'b01) ? vecs[k].a0 :
                (vecs[k].expReady == 2'b10) ? vecs[k].a1 : '0;
      expData = (vecs[k].expReady == 2'b01) ? data_of(0, vecs[k].a0) :
                (vecs[k].expReady == 2'b10) ? data_of(1, vecs[k].a1) : '0;
      @(negedge clk);
      check({vecs[k].name, ".ready"}, 128'(bus.wr_req_ready), 128'(vecs[k].expReady));
      check({vecs[k].name, ".wr_en"}, 128'(ram_wr_en), 128'(|vecs[k].expReady));
      check({vecs[k].name, ".addr"}, 128'(ram_wr_addr), 128'(expAddr));
      check({vecs[k].name, ".data"}, ram_wr_data, expData);
    end

    // Read latency: write 0xA5A5 to addr 5, then client1 reads it back
    step();
    idle_inputs();
    drive_wr(2'b01, 2'b01, 32'h5, 128'hA5A5, 32'h0, 128'h0);
    @(negedge clk);
    check("lat_wr_ready", 128'(bus.wr_req_ready), 128'(2'b01));
    step();
    idle_inputs();
    drive_rd(2'b10, 2'b10, 32'h0, 32'h5);
    expect_rsp(2'b10, 128'hA5A5);
    @(negedge clk);
    check("lat_rd_ready", 128'(bus.rd_req_ready), 128'(2'b10));
    check("lat_rd_en", 128'(ram_rd_en), 128'(1));
    check("lat_rd_addr", 128'(ram_rd_addr), 128'(5));
    step();
    idle_inputs();

    // Same-cycle collision on addr 7 (old 0x9, new 0x1)
    step();
    drive_wr(2'b01, 2'b01, 32'h7, 128'h9, 32'h0, 128'h0);
    step();
    drive_wr(2'b01, 2'b01, 32'h7, 128'h1, 32'h0, 128'h0);
    drive_rd(2'b01, 2'b01, 32'h7, 32'h0);
    expect_rsp(2'b01, collExp);
    @(negedge clk);
    check("coll_wr_ready", 128'(bus.wr_req_ready), 128'(2'b01));
    check("coll_rd_ready", 128'(bus.rd_req_ready), 128'(2'b01));
    step();
    idle_inputs();

    // Read round robin: read ptr is 1, so client1 goes first
    step();
    drive_rd(2'b11, 2'b11, 32'h5, 32'h7);
    expect_rsp(2'b10, 128'h1);
    @(negedge clk);
    check("rd_rr_0", 128'(bus.rd_req_ready), 128'(2'b10));
    step();
    drive_rd(2'b01, 2'b01, 32'h5, 32'h7);
    expect_rsp(2'b01, 128'hA5A5);
    @(negedge clk);
    check("rd_rr_1", 128'(bus.rd_req_ready), 128'(2'b01));

    // Reset during beat 2 of a 4-beat client0 read burst
    step();
    drive_rd(2'b01, 2'b00, 32'h5, 32'h7);
    expect_rsp(2'b01, 128'hA5A5);
    @(negedge clk);
    check("rdrst_b1_ready", 128'(bus.rd_req_ready), 128'(2'b01));
    step();
    rst = 1'b1;
    drive_rd(2'b11, 2'b00, 32'h6, 32'h7);
    drive_wr(2'b01, 2'b01, 32'h7, 128'hDEAD, 32'h0, 128'h0);
    @(negedge clk);
    check("rdrst_rd_ready", 128'(bus.rd_req_ready), 128'(0));
    check("rdrst_wr_ready", 128'(bus.wr_req_ready), 128'(0));
    check("rdrst_ram_en", 128'({ram_wr_en, ram_rd_en}), 128'(0));
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rdrst_after_ready", 128'(bus.rd_req_ready), 128'(0));
    check("rdrst_after_rsp", 128'(bus.rd_rsp_valid), 128'(0));
    step();
    drive_rd(2'b10, 2'b10, 32'h0, 32'h7);
    expect_rsp(2'b10, 128'h1);
    @(negedge clk);
    check("rdrst_c1_first", 128'(bus.rd_req_ready), 128'(2'b10));
    step();
    idle_inputs();
    step();
    @(negedge clk);
    check("sb_drained", 128'(sbQ.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
